// File: rtl/gshare_btb_predictor.sv
// gshare_btb_predictor: fetch-stage direction/target predictor.
// A gshare PHT of 2-bit counters indexed by PC xor speculative history,
// a direct-mapped tagged BTB, a speculative GHR repaired on mispredict,
// and saturating branch/mispredict performance counters.
module gshare_btb_predictor #(
  parameter int XLEN    = 32,
  parameter int PHT_IDX = 10,
  parameter int GHR_LEN = 8,
  parameter int BTB_IDX = 6,
  parameter int TAG_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               f_valid,
  input  logic               f_stall,
  input  logic [XLEN-1:0]    f_pc,
  input  logic               f_is_branch,
  output logic               f_taken,
  output logic [XLEN-1:0]    f_target,
  output logic               f_btb_hit,
  output logic [GHR_LEN-1:0] f_ghr,
  input  logic               ex_valid,
  input  logic               ex_is_cond,
  input  logic [XLEN-1:0]    ex_pc,
  input  logic               ex_taken,
  input  logic [XLEN-1:0]    ex_target,
  input  logic [GHR_LEN-1:0] ex_ghr,
  input  logic               ex_mispredict,
  output logic [31:0]        perf_branches,
  output logic [31:0]        perf_mispredicts
);

  localparam int PHT_N = 1 << PHT_IDX;
  localparam int BTB_N = 1 << BTB_IDX;

  logic [1:0]         pht        [PHT_N];
  logic               btb_valid  [BTB_N];
  logic [TAG_W-1:0]   btb_tag    [BTB_N];
  logic [XLEN-1:0]    btb_target [BTB_N];
  logic [GHR_LEN-1:0] ghr_spec;

  logic [PHT_IDX-1:0] f_pht_idx, ex_pht_idx;
  logic [BTB_IDX-1:0] f_btb_idx, ex_btb_idx;
  logic [TAG_W-1:0]   f_tag, ex_tag;
  logic               ex_train, ex_recover, f_shift;

  // History is zero-extended into the PC index; F uses the live speculative
  // history, EX uses the snapshot that travelled with the branch.
  assign f_pht_idx  = f_pc[PHT_IDX+1:2] ^ PHT_IDX'(ghr_spec);
  assign ex_pht_idx = ex_pc[PHT_IDX+1:2] ^ PHT_IDX'(ex_ghr);
  assign f_btb_idx  = f_pc[BTB_IDX+1:2];
  assign ex_btb_idx = ex_pc[BTB_IDX+1:2];
  assign f_tag      = f_pc[BTB_IDX+TAG_W+1:BTB_IDX+2];
  assign ex_tag     = ex_pc[BTB_IDX+TAG_W+1:BTB_IDX+2];

  assign ex_train   = ex_valid & ex_is_cond;
  assign ex_recover = ex_train & ex_mispredict;
  assign f_shift    = f_valid & f_is_branch & ~f_stall;

  // Lookup reads registered state only, so a same-cycle write is not seen.
  assign f_btb_hit = btb_valid[f_btb_idx] && (btb_tag[f_btb_idx] == f_tag);
  assign f_taken   = f_valid & f_is_branch & pht[f_pht_idx][1] & f_btb_hit;
  assign f_target  = f_btb_hit ? btb_target[f_btb_idx] : '0;
  assign f_ghr     = ghr_spec;

  // PC bits outside the index/tag fields are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{f_pc, ex_pc};

  // PHT: saturating 2-bit counter training from EX.
  // NOTE: tables are reset entry by entry because reset must leave every
  // counter weakly not-taken; an unreset RAM would start with garbage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
    end else if (ex_train) begin
      if (ex_taken && pht[ex_pht_idx] != 2'b11)
        pht[ex_pht_idx] <= pht[ex_pht_idx] + 2'd1;
      else if (!ex_taken && pht[ex_pht_idx] != 2'b00)
        pht[ex_pht_idx] <= pht[ex_pht_idx] - 2'd1;
    end
  end

  // BTB: allocate/overwrite on every resolved taken conditional branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_N; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
    end else if (ex_train && ex_taken) begin
      btb_valid[ex_btb_idx]  <= 1'b1;
      btb_tag[ex_btb_idx]    <= ex_tag;
      btb_target[ex_btb_idx] <= ex_target;
    end
  end

  // GHR: mispredict recovery wins over the speculative fetch shift.
  // NOTE: non-blocking assignments keep every register sampling pre-edge
  // values, so ordering between always_ff blocks cannot change behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             ghr_spec <= '0;
    else if (ex_recover) ghr_spec <= {ex_ghr[GHR_LEN-2:0], ex_taken};
    else if (f_shift)    ghr_spec <= {ghr_spec[GHR_LEN-2:0], f_taken};
  end

  // Performance counters, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (ex_train && perf_branches != '1)
        perf_branches <= perf_branches + 32'd1;
      if (ex_recover && perf_mispredicts != '1)
        perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Self-checking bench for gshare_btb_predictor: expected lookup results are
// queued when a lookup is driven and popped when the outputs are sampled.
`timescale 1ns/1ps
module tb_gshare_btb_predictor;

  typedef struct packed {
    logic        taken;
    logic        hit;
    logic [31:0] target;
    logic [7:0]  ghr;
  } look_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_valid, f_stall, f_is_branch;
  logic [31:0] f_pc;
  logic        f_taken, f_btb_hit;
  logic [31:0] f_target;
  logic [7:0]  f_ghr;
  logic        ex_valid, ex_is_cond, ex_taken, ex_mispredict;
  logic [31:0] ex_pc, ex_target;
  logic [7:0]  ex_ghr;
  logic [31:0] perf_branches, perf_mispredicts;

  look_t exp_q[$];
  look_t e;
  int    n_pass  = 0;
  int    n_total = 0;

  gshare_btb_predictor dut (
    .clk(clk), .rst(rst),
    .f_valid(f_valid), .f_stall(f_stall), .f_pc(f_pc), .f_is_branch(f_is_branch),
    .f_taken(f_taken), .f_target(f_target), .f_btb_hit(f_btb_hit), .f_ghr(f_ghr),
    .ex_valid(ex_valid), .ex_is_cond(ex_is_cond), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_ghr(ex_ghr), .ex_mispredict(ex_mispredict),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Drive a lookup at the falling edge and queue its expected result.
  task automatic drive_lookup(input logic [31:0] pc, input logic br,
                              input logic stall, input look_t exp);
    @(negedge clk);
    f_valid = 1'b1; f_pc = pc; f_is_branch = br; f_stall = stall;
    exp_q.push_back(exp);
    #2;
  endtask

  // Apply one EX resolution across a single rising edge; fetch is idle.
  task automatic ex_update(input logic [31:0] pc, input logic [7:0] ghr,
                           input logic cond, input logic taken,
                           input logic [31:0] tgt, input logic mis);
    @(negedge clk);
    f_valid = 1'b0; f_is_branch = 1'b0; f_stall = 1'b0;
    ex_valid = 1'b1; ex_is_cond = cond; ex_pc = pc; ex_ghr = ghr;
    ex_taken = taken; ex_target = tgt; ex_mispredict = mis;
    @(posedge clk);
    #1 ex_valid = 1'b0;
  endtask

  task automatic test_reset;
    drive_lookup(32'h100, 1'b1, 1'b0, look_t'{1'b0, 1'b0, 32'h0, 8'h00});
    e = exp_q.pop_front(); n_total++;
    if ({f_taken, f_btb_hit, f_target, f_ghr} !== e)
      $display("FAIL cold_lookup: got %h required %h", {f_taken, f_btb_hit, f_target, f_ghr}, e);
    else n_pass++;
    n_total++;
    if (perf_branches !== 32'd0) $display("FAIL reset_perf_br: got %0d required 0", perf_branches);
    else n_pass++;
    n_total++;
    if (perf_mispredicts !== 32'd0) $display("FAIL reset_perf_mis: got %0d required 0", perf_mispredicts);
    else n_pass++;
    // The cold branch crossed an edge unstalled, shifting in a 0.
    drive_lookup(32'h100, 1'b0, 1'b0, look_t'{1'b0, 1'b0, 32'h0, 8'h00});
    e = exp_q.pop_front(); n_total++;
    if ({f_taken, f_btb_hit, f_target, f_ghr} !== e)
      $display("FAIL cold_shift: got %h required %h", {f_taken, f_btb_hit, f_target, f_ghr}, e);
    else n_pass++;
  endtask

  task automatic test_train_hit;
    ex_update(32'h100, 8'h00, 1'b1, 1'b1, 32'h80, 1'b0);
    drive_lookup(32'h100, 1'b1, 1'b1, look_t'{1'b1, 1'b1, 32'h80, 8'h00});
    e = exp_q.pop_front(); n_total++;
    if ({f_taken, f_btb_hit, f_target, f_ghr} !== e)
      $display("FAIL train_hit: got %h required %h", {f_taken, f_btb_hit, f_target, f_ghr}, e);
    else n_pass++;
    n_total++;
    if (perf_branches !== 32'd1) $display("FAIL train_perf_br: got %0d required 1", perf_branches);
    else n_pass++;
    n_total++;
    if (perf_mispredicts !== 32'd0) $display("FAIL train_perf_mis: got %0d required 0", perf_mispredicts);
    else n_pass++;
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 4; i++) ex_update(32'h100, 8'h00, 1'b1, 1'b1, 32'h80, 1'b0);
    ex_update(32'h100, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0);
    drive_lookup(32'h100, 1'b1, 1'b1, look_t'{1'b1, 1'b1, 32'h80, 8'h00});
    e = exp_q.pop_front(); n_total++;
    if ({f_taken, f_btb_hit, f_target, f_ghr} !== e)
      $display("FAIL sat_weak_taken: got %h required %h", {f_taken, f_btb_hit, f_target, f_ghr}, e);
    else n_pass++;
    for (int i = 0; i < 2; i++) ex_update(32'h100, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0);
    // Counter at 00; the BTB entry survives not-taken resolutions.
    drive_lookup(32'h100, 1'b1, 1'b1, look_t'{1'b0, 1'b1, 32'h80, 8'h00});
    e = exp_q.pop_front(); n_total++;
    if ({f_taken, f_btb_hit, f_target, f_ghr} !== e)
      $display("FAIL sat_not_taken: got %h required %h", {f_taken, f_btb_hit, f_target, f_ghr}, e);
    else n_pass++;
    n_total++;
    if (perf_branches !== 32'd8) $display("FAIL sat_perf_br: got %0d required 8", perf_branches);
    else n_pass++;
  endtask

  task automatic test_alias;
    drive_lookup(32'h200, 1'b1, 1'b1, look_t'{1'b0, 1'b0, 32'h0, 8'h00});
    e = exp_q.pop_front(); n_total++;
    if ({f_taken, f_btb_hit, f_target, f_ghr} !== e)
      $display("FAIL btb_alias: got %h required %h", {f_taken, f_btb_hit, f_target, f_ghr}, e);
    else n_pass++;
  endtask

  task automatic test_recovery;
    // Recovery from snapshot 0x52 with taken=1 loads 0xA5.
    ex_update(32'h404, 8'h52, 1'b1, 1'b1, 32'h900, 1'b1);
    drive_lookup(32'h404, 1'b0, 1'b0, look_t'{1'b0, 1'b1, 32'h900, 8'hA5});
    e = exp_q.pop_front(); n_total++;
    if ({f_taken, f_btb_hit, f_target, f_ghr} !== e)
      $display("FAIL ghr_load: got %h required %h", {f_taken, f_btb_hit, f_target, f_ghr}, e);
    else n_pass++;
    // Fetch branch and EX mispredict in the same cycle.
    @(negedge clk);
    f_valid = 1'b1; f_pc = 32'h100; f_is_branch = 1'b1; f_stall = 1'b0;
    ex_valid = 1'b1; ex_is_cond = 1'b1; ex_pc = 32'h404; ex_ghr = 8'h03;
    ex_taken = 1'b1; ex_target = 32'h900; ex_mispredict = 1'b1;
    @(posedge clk);
    #1 ex_valid = 1'b0; f_is_branch = 1'b0;
    drive_lookup(32'h404, 1'b0, 1'b0, look_t'{1'b0, 1'b1, 32'h900, 8'h07});
    e = exp_q.pop_front(); n_total++;
    if ({f_taken, f_btb_hit, f_target, f_ghr} !== e)
      $display("FAIL recovery_priority: got %h required %h", {f_taken, f_btb_hit, f_target, f_ghr}, e);
    else n_pass++;
    n_total++;
    if (perf_mispredicts !== 32'd2) $display("FAIL recovery_perf_mis: got %0d required 2", perf_mispredicts);
    else n_pass++;
  endtask

  task automatic test_non_cond;
    ex_update(32'h800, 8'hFF, 1'b0, 1'b1, 32'h123, 1'b1);
    drive_lookup(32'h800, 1'b0, 1'b0, look_t'{1'b0, 1'b0, 32'h0, 8'h07});
    e = exp_q.pop_front(); n_total++;
    if ({f_taken, f_btb_hit, f_target, f_ghr} !== e)
      $display("FAIL non_cond_ignored: got %h required %h", {f_taken, f_btb_hit, f_target, f_ghr}, e);
    else n_pass++;
    n_total++;
    if ({perf_branches, perf_mispredicts} !== {32'd10, 32'd2})
      $display("FAIL non_cond_perf: got %0d/%0d required 10/2", perf_branches, perf_mispredicts);
    else n_pass++;
  endtask

  task automatic test_stall;
    drive_lookup(32'h404, 1'b1, 1'b1, look_t'{1'b0, 1'b1, 32'h900, 8'h07});
    e = exp_q.pop_front(); n_total++;
    if ({f_taken, f_btb_hit, f_target, f_ghr} !== e)
      $display("FAIL stall_lookup: got %h required %h", {f_taken, f_btb_hit, f_target, f_ghr}, e);
    else n_pass++;
    drive_lookup(32'h404, 1'b0, 1'b0, look_t'{1'b0, 1'b1, 32'h900, 8'h07});
    e = exp_q.pop_front(); n_total++;
    if ({f_taken, f_btb_hit, f_target, f_ghr} !== e)
      $display("FAIL stall_no_shift: got %h required %h", {f_taken, f_btb_hit, f_target, f_ghr}, e);
    else n_pass++;
  endtask

  task automatic test_async_reset;
    drive_lookup(32'h404, 1'b1, 1'b1, look_t'{1'b0, 1'b0, 32'h0, 8'h00});
    rst = 1'b1;
    #1;
    e = exp_q.pop_front(); n_total++;
    if ({f_taken, f_btb_hit, f_target, f_ghr} !== e)
      $display("FAIL async_reset_outputs: got %h required %h", {f_taken, f_btb_hit, f_target, f_ghr}, e);
    else n_pass++;
    n_total++;
    if ({perf_branches, perf_mispredicts} !== 64'd0)
      $display("FAIL async_reset_perf: got %0d/%0d required 0/0", perf_branches, perf_mispredicts);
    else n_pass++;
    @(negedge clk) rst = 1'b0;
    // First edge after release is functional.
    ex_update(32'h100, 8'h00, 1'b1, 1'b1, 32'h80, 1'b1);
    n_total++;
    if ({perf_branches, perf_mispredicts} !== {32'd1, 32'd1})
      $display("FAIL post_reset_edge: got %0d/%0d required 1/1", perf_branches, perf_mispredicts);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    f_valid = 1'b0; f_stall = 1'b0; f_pc = '0; f_is_branch = 1'b0;
    ex_valid = 1'b0; ex_is_cond = 1'b0; ex_pc = '0; ex_taken = 1'b0;
    ex_target = '0; ex_ghr = '0; ex_mispredict = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_train_hit();
    test_saturation();
    test_alias();
    test_recovery();
    test_non_cond();
    test_stall();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
